// File: rtl/rrag_agu_sb.sv
// rtl/rrag_agu_sb.sv - register-read/address-generation stage with pending-writer scoreboard (optional macro: RRAG_PAGE_SPLIT_EN)
module rrag_agu_sb #(
    parameter int NCH  = 2,
    parameter int NREG = 8,
    parameter int AW   = 32,
    parameter int CNTW = 3,
    localparam int RAW = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NCH-1:0]     in_ch_en,
    input  logic [NCH-1:0]     in_base_use,
    input  logic [NCH-1:0]     in_idx_use,
    input  logic [NCH*RAW-1:0] in_base_reg,
    input  logic [NCH*RAW-1:0] in_idx_reg,
    input  logic [NCH*AW-1:0]  in_base_val,
    input  logic [NCH*AW-1:0]  in_idx_val,
    input  logic [NCH*2-1:0]   in_scale,
    input  logic [NCH*AW-1:0]  in_disp,
    input  logic [NCH*16-1:0]  in_seg,
    input  logic [1:0]         in_size,
    input  logic [NREG-1:0]    in_dest_mask,
    input  logic               wb_valid,
    input  logic [NREG-1:0]    wb_mask,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NCH*AW-1:0]  out_addr,
    output logic [NCH*AW-1:0]  out_end,
    output logic [NCH-1:0]     out_ch_en,
    output logic [NCH-1:0]     out_split,
    output logic               out_beat,
    output logic [NREG-1:0]    sb_busy,
    output logic               sb_err
);

    typedef enum logic [1:0] {EMPTY = 2'd0, FULL0 = 2'd1, FULL1 = 2'd2} state_t;

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt [NREG];
    logic [AW-1:0]   base_e [NCH];
    logic [AW-1:0]   idx_e [NCH];
    logic [AW-1:0]   addr_c [NCH];
    logic [AW-1:0]   end_c [NCH];
    logic [NCH-1:0]  split_c;
    logic [AW-1:0]   addr_q [NCH];
    logic [AW-1:0]   end_q [NCH];
    logic [NCH-1:0]  ch_en_q;
    logic [NCH-1:0]  split_q;
    logic [AW-1:0]   size_m1;
    logic            dep, sat, accept, split_pending;

    assign size_m1       = (AW'(1) << in_size) - AW'(1);
    assign split_pending = |split_q;
    assign accept        = in_valid & in_ready;
    assign in_ready      = ~dep & ~sat & ~flush &
                           ((state == EMPTY) | ((state == FULL0) & ~split_pending & out_ready));

    // Per-channel effective address, end address and page-crossing detection
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            base_e[c] = in_base_use[c] ? in_base_val[c*AW +: AW] : '0;
            idx_e[c]  = in_idx_use[c] ? in_idx_val[c*AW +: AW] : '0;
            addr_c[c] = AW'({in_seg[c*16 +: 16], 16'h0000}) + base_e[c]
                      + (idx_e[c] << in_scale[c*2 +: 2]) + in_disp[c*AW +: AW];
            end_c[c]  = addr_c[c] + size_m1;
`ifdef RRAG_PAGE_SPLIT_EN
            split_c[c] = in_ch_en[c] & (addr_c[c][AW-1:12] != end_c[c][AW-1:12]);
`else
            split_c[c] = 1'b0;
`endif
        end
    end

    // Issue stalls: in-flight producers of used registers, and counters about to overflow
    always_comb begin
        dep = 1'b0;
        sat = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (in_ch_en[c]) begin
                if (in_base_use[c] && (cnt[in_base_reg[c*RAW +: RAW]] != '0)) dep = 1'b1;
                if (in_idx_use[c] && (cnt[in_idx_reg[c*RAW +: RAW]] != '0)) dep = 1'b1;
            end
        end
        for (int r = 0; r < NREG; r++) begin
            sb_busy[r] = |cnt[r];
            if (in_dest_mask[r] && (cnt[r] == '1)) sat = 1'b1;
        end
    end

    // Scoreboard counters: issue increments, writeback decrements, flush clears
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            sb_err <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if ((accept & in_dest_mask[r]) & ~(wb_valid & wb_mask[r])) begin
                    cnt[r] <= cnt[r] + CNTW'(1);
                end else if ((wb_valid & wb_mask[r]) & ~(accept & in_dest_mask[r])) begin
                    if (cnt[r] == '0) sb_err <= 1'b1;
                    else              cnt[r] <= cnt[r] - CNTW'(1);
                end
            end
        end
    end

    // Output latch payload, captured on every accepted instruction
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int c = 0; c < NCH; c++) begin
                addr_q[c] <= '0;
                end_q[c]  <= '0;
            end
            ch_en_q <= '0;
            split_q <= '0;
        end else if (accept) begin
            for (int c = 0; c < NCH; c++) begin
                addr_q[c] <= addr_c[c];
                end_q[c]  <= end_c[c];
            end
            ch_en_q <= in_ch_en;
            split_q <= split_c;
        end
    end

    // Output FSM state register
    always_ff @(posedge clk) begin
        if (!clr) state <= EMPTY;
        else      state <= state_nx;
    end

    // Output FSM next state; flush overrides everything
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nx = FULL0;
                FULL0: begin
                    if (out_ready) begin
                        if (split_pending) state_nx = FULL1;
                        else if (accept)   state_nx = FULL0;
                        else               state_nx = EMPTY;
                    end
                end
                FULL1:   if (out_ready) state_nx = EMPTY;
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Output FSM outputs: beat 0 clips split channels at the page end, beat 1 carries the remainder
    always_comb begin
        out_valid = (state != EMPTY);
        out_addr  = '0;
        out_end   = '0;
        out_ch_en = '0;
        out_split = '0;
        out_beat  = 1'b0;
        case (state)
            FULL0: begin
                out_ch_en = ch_en_q;
                out_split = split_q;
                for (int c = 0; c < NCH; c++) begin
                    out_addr[c*AW +: AW] = addr_q[c];
                    out_end[c*AW +: AW]  = split_q[c] ? {addr_q[c][AW-1:12], 12'hFFF} : end_q[c];
                end
            end
            FULL1: begin
                out_beat  = 1'b1;
                out_ch_en = split_q;
                out_split = split_q;
                for (int c = 0; c < NCH; c++) begin
                    if (split_q[c]) begin
                        out_addr[c*AW +: AW] = {end_q[c][AW-1:12], 12'h000};
                        out_end[c*AW +: AW]  = end_q[c];
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rrag_agu_sb.sv
// tb/tb_rrag_agu_sb.sv - randomized self-checking bench for rrag_agu_sb against a behavioural model
module tb_rrag_agu_sb;
    localparam int NCH = 2, NREG = 8, AW = 32, CNTW = 3, RAW = 3;

    logic clk = 1'b0;
    logic clr, in_valid, in_ready, wb_valid, flush, out_valid, out_ready, out_beat, sb_err;
    logic [NCH-1:0]     in_ch_en, in_base_use, in_idx_use, out_ch_en, out_split;
    logic [NCH*RAW-1:0] in_base_reg, in_idx_reg;
    logic [NCH*AW-1:0]  in_base_val, in_idx_val, in_disp, out_addr, out_end;
    logic [NCH*2-1:0]   in_scale;
    logic [NCH*16-1:0]  in_seg;
    logic [1:0]         in_size;
    logic [NREG-1:0]    in_dest_mask, wb_mask, sb_busy;

    always #5 clk = ~clk;

    rrag_agu_sb #(.NCH(NCH), .NREG(NREG), .AW(AW), .CNTW(CNTW)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch_en(in_ch_en), .in_base_use(in_base_use), .in_idx_use(in_idx_use),
        .in_base_reg(in_base_reg), .in_idx_reg(in_idx_reg),
        .in_base_val(in_base_val), .in_idx_val(in_idx_val), .in_scale(in_scale),
        .in_disp(in_disp), .in_seg(in_seg), .in_size(in_size), .in_dest_mask(in_dest_mask),
        .wb_valid(wb_valid), .wb_mask(wb_mask), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_end(out_end),
        .out_ch_en(out_ch_en), .out_split(out_split), .out_beat(out_beat),
        .sb_busy(sb_busy), .sb_err(sb_err)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending-write counts per register and the instruction held at the output
    int             cnt_m [NREG];
    bit             err_m, mv, mb, m_init, acc_m, rdy_m;
    logic [AW-1:0]  ma [NCH];
    logic [AW-1:0]  me [NCH];
    logic [NCH-1:0] mch, msp;

    function automatic bit model_ready();
        bit blocked = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (in_ch_en[c]) begin
                if (in_base_use[c] && cnt_m[in_base_reg[c*RAW +: RAW]] != 0) blocked = 1'b1;
                if (in_idx_use[c] && cnt_m[in_idx_reg[c*RAW +: RAW]] != 0) blocked = 1'b1;
            end
        end
        for (int r = 0; r < NREG; r++)
            if (in_dest_mask[r] && cnt_m[r] == (1 << CNTW) - 1) blocked = 1'b1;
        if (flush) blocked = 1'b1;
        if (mv && !(!mb && msp == 0 && out_ready)) blocked = 1'b1;
        return !blocked;
    endfunction

    task automatic model_edge();
        logic [AW-1:0] a, e, b, x;
        if (!clr) begin
            for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
            err_m = 0; mv = 0; mb = 0; msp = '0; m_init = 1;
            return;
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
            mv = 0; mb = 0;
            return;
        end
        for (int r = 0; r < NREG; r++) begin
            bit inc, dec;
            inc = acc_m && in_dest_mask[r];
            dec = wb_valid && wb_mask[r];
            if (inc && !dec) cnt_m[r]++;
            else if (dec && !inc) begin
                if (cnt_m[r] == 0) err_m = 1;
                else cnt_m[r]--;
            end
        end
        if (mv && out_ready && !mb && msp != 0) begin
            mb = 1;
        end else if (acc_m) begin
            for (int c = 0; c < NCH; c++) begin
                b = in_base_use[c] ? in_base_val[c*AW +: AW] : 0;
                x = in_idx_use[c] ? in_idx_val[c*AW +: AW] : 0;
                a = {in_seg[c*16 +: 16], 16'h0000} + b + (x << in_scale[c*2 +: 2]) + in_disp[c*AW +: AW];
                e = a + (1 << in_size) - 1;
                ma[c] = a;
                me[c] = e;
                msp[c] = 1'b0;
`ifdef RRAG_PAGE_SPLIT_EN
                msp[c] = in_ch_en[c] && (a[AW-1:12] != e[AW-1:12]);
`endif
            end
            mch = in_ch_en; mv = 1; mb = 0;
        end else if (mv && out_ready) begin
            mv = 0; mb = 0;
        end
    endtask

    task automatic compare_outputs();
        logic [NCH*AW-1:0] ea, ee;
        logic [NREG-1:0]   eb;
        for (int r = 0; r < NREG; r++) eb[r] = (cnt_m[r] != 0);
        chk("sb_busy", sb_busy, eb);
        chk("sb_err", sb_err, err_m);
        chk("out_valid", out_valid, mv);
        if (mv) begin
            ea = '0; ee = '0;
            for (int c = 0; c < NCH; c++) begin
                if (!mb) begin
                    ea[c*AW +: AW] = ma[c];
                    ee[c*AW +: AW] = msp[c] ? {ma[c][AW-1:12], 12'hFFF} : me[c];
                end else if (msp[c]) begin
                    ea[c*AW +: AW] = {me[c][AW-1:12], 12'h000};
                    ee[c*AW +: AW] = me[c];
                end
            end
            chk("out_addr", out_addr, ea);
            chk("out_end", out_end, ee);
            chk("out_ch_en", out_ch_en, mb ? msp : mch);
            chk("out_split", out_split, msp);
            chk("out_beat", out_beat, mb);
        end
    endtask

    // Compare process: in_ready mid-cycle, registered outputs just after each edge
    initial begin
        m_init = 0;
        forever begin
            @(negedge clk);
            #3;
            rdy_m = model_ready();
            acc_m = in_valid && rdy_m;
            if (m_init && clr) chk("in_ready", in_ready, rdy_m);
            @(posedge clk);
            model_edge();
            #1;
            if (m_init) compare_outputs();
        end
    end

    task automatic idle();
        in_valid = 0; in_ch_en = '0; in_base_use = '0; in_idx_use = '0;
        in_base_reg = '0; in_idx_reg = '0; in_base_val = '0; in_idx_val = '0;
        in_scale = '0; in_disp = '0; in_seg = '0; in_size = '0; in_dest_mask = '0;
        wb_valid = 0; wb_mask = '0; flush = 0; out_ready = 1;
    endtask

    task automatic rand_inputs();
        idle();
        clr = ($urandom_range(0, 199) != 0);
        flush = ($urandom_range(0, 49) == 0);
        in_valid = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 3) != 0);
        in_ch_en = NCH'($urandom);
        in_base_use = NCH'($urandom);
        in_idx_use = NCH'($urandom);
        in_base_reg = (NCH*RAW)'($urandom);
        in_idx_reg = (NCH*RAW)'($urandom);
        in_size = 2'($urandom);
        in_scale = (NCH*2)'($urandom);
        for (int c = 0; c < NCH; c++) begin
            in_base_val[c*AW +: AW] = $urandom;
            in_idx_val[c*AW +: AW] = $urandom;
            in_seg[c*16 +: 16] = 16'($urandom);
            in_disp[c*AW +: AW] = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                in_base_use[c] = 1'b0;
                in_idx_use[c] = 1'b0;
                in_disp[c*AW +: AW] = {$urandom_range(0, 65535) << 12} | (32'hFFF - $urandom_range(0, 6));
            end
        end
        if ($urandom_range(0, 2) == 0) in_dest_mask[$urandom_range(0, NREG-1)] = 1'b1;
        if ($urandom_range(0, 5) == 0) in_dest_mask[$urandom_range(0, NREG-1)] = 1'b1;
        for (int r = 0; r < NREG; r++)
            if (cnt_m[r] > 0 && $urandom_range(0, 3) == 0) wb_mask[r] = 1'b1;
        if ($urandom_range(0, 49) == 0) wb_mask[$urandom_range(0, NREG-1)] = 1'b1;
        wb_valid = (wb_mask != 0);
    endtask

    initial begin
        clr = 0;
        idle();
        repeat (2) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset sb_busy", sb_busy, 0);
        chk("reset sb_err", sb_err, 0);
        chk("reset out_addr", out_addr, 0);
        chk("reset out_end", out_end, 0);
        clr = 1;

        // Basic address generation
        @(negedge clk);
        in_valid = 1; in_ch_en = 2'b01; in_seg[15:0] = 16'h1000;
        in_base_use = 2'b01; in_base_val[31:0] = 32'h20; in_base_reg[2:0] = 3'd0;
        in_idx_use = 2'b01; in_idx_val[31:0] = 32'h4; in_idx_reg[2:0] = 3'd1;
        in_scale[1:0] = 2'd2; in_disp[31:0] = 32'h8; in_size = 2'd2;
        #1 chk("basic in_ready", in_ready, 1);
        @(negedge clk);
        chk("basic out_valid", out_valid, 1);
        chk("basic addr", out_addr[31:0], 32'h1000_0038);
        chk("basic end", out_end[31:0], 32'h1000_003B);
        idle();

        // Dependency stall on r0 and its release by writeback
        @(negedge clk);
        in_valid = 1; in_dest_mask = 8'h01;
        @(negedge clk);
        chk("dep busy", sb_busy, 8'h01);
        in_dest_mask = 8'h00; in_ch_en = 2'b01; in_base_use = 2'b01; in_base_reg = '0;
        #1 chk("dep stall", in_ready, 0);
        @(negedge clk);
        wb_valid = 1; wb_mask = 8'h01;
        #1 chk("dep stall wb cycle", in_ready, 0);
        @(negedge clk);
        wb_valid = 0; wb_mask = '0;
        #1 chk("dep released", in_ready, 1);
        @(negedge clk);
        idle();

        // Same-cycle issue and writeback on r3; underflow on r5
        @(negedge clk);
        in_valid = 1; in_dest_mask = 8'h08;
        @(negedge clk);
        wb_valid = 1; wb_mask = 8'h08;
        @(negedge clk);
        chk("same-cycle r3 busy", sb_busy, 8'h08);
        idle();
        wb_valid = 1; wb_mask = 8'h08;
        @(negedge clk);
        chk("r3 drained", sb_busy, 8'h00);
        chk("no err yet", sb_err, 0);
        wb_mask = 8'h20;
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("underflow err", sb_err, 1);

        // Saturation of r2 at 7 pending writes
        repeat (7) begin
            @(negedge clk);
            in_valid = 1; in_dest_mask = 8'h04;
        end
        @(negedge clk);
        chk("sat busy", sb_busy, 8'h04);
        #1 chk("sat stall", in_ready, 0);
        wb_valid = 1; wb_mask = 8'h04;
        @(negedge clk);
        wb_valid = 0; wb_mask = '0;
        #1 chk("sat released", in_ready, 1);
        @(negedge clk);
        in_valid = 0; in_dest_mask = '0; out_ready = 0;
        @(negedge clk);
        chk("held before flush", out_valid, 1);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush out_valid", out_valid, 0);
        chk("flush sb_busy", sb_busy, 0);
        chk("flush keeps err", sb_err, 1);
        idle();

`ifdef RRAG_PAGE_SPLIT_EN
        // Page split: 4-byte access at 0xFFE
        @(negedge clk);
        in_valid = 1; in_ch_en = 2'b01; in_disp[31:0] = 32'hFFE; in_size = 2'd2;
        in_dest_mask = 8'h40; out_ready = 0;
        @(negedge clk);
        in_valid = 0; in_dest_mask = '0;
        chk("split b0 end", out_end[31:0], 32'h0000_0FFF);
        chk("split b0 flag", out_split, 2'b01);
        chk("split b0 beat", out_beat, 0);
        repeat (2) begin
            @(negedge clk);
            chk("split b0 stable addr", out_addr[31:0], 32'h0000_0FFE);
            chk("split b0 stable end", out_end[31:0], 32'h0000_0FFF);
        end
        out_ready = 1;
        @(negedge clk);
        chk("split b1 beat", out_beat, 1);
        chk("split b1 addr", out_addr[31:0], 32'h0000_1000);
        chk("split b1 end", out_end[31:0], 32'h0000_1001);
        out_ready = 0; flush = 1;
        @(negedge clk);
        chk("flush b1 out_valid", out_valid, 0);
        chk("flush b1 sb_busy", sb_busy, 0);
        idle();
`endif

        // Reset mid-stream
        @(negedge clk);
        in_valid = 1; in_ch_en = 2'b11; in_disp = {32'h1234_5678, 32'h0000_0FFD};
        in_size = 2'd3; in_dest_mask = 8'h10;
        @(negedge clk);
        in_valid = 0; in_dest_mask = '0; out_ready = 0; clr = 0;
        @(negedge clk);
        chk("clr out_valid", out_valid, 0);
        chk("clr out_addr", out_addr, 0);
        chk("clr out_end", out_end, 0);
        chk("clr out_ch_en", out_ch_en, 0);
        chk("clr out_split", out_split, 0);
        chk("clr out_beat", out_beat, 0);
        chk("clr sb_busy", sb_busy, 0);
        chk("clr sb_err", sb_err, 0);
        clr = 1;
        idle();

        // Randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            rand_inputs();
        end
        @(negedge clk);
        clr = 1;
        idle();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
